// File: rtl/max_search_ctrl_pkg.sv
// Shared types and default sizing for the max-search controller and its step counter.
package max_search_ctrl_pkg;

    localparam int N_OPS_DEF = 4;
    localparam int IDX_W_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/max_search_ctrl_step_counter.sv
// Operand step counter: cleared on rst or clr, counts while enabled and holds at N_OPS-1.
module max_search_ctrl_step_counter #(
    parameter int N_OPS = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [IDX_W-1:0] count,
    output logic             tc
);

    assign tc = (count == IDX_W'(N_OPS - 1));

    // Saturating at the terminal count keeps sel from wrapping back to operand 0 within a scan.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/max_search_ctrl.sv
// Controller that walks the shared compare datapath over N_OPS operands and tracks the winning index.
module max_search_ctrl
    import max_search_ctrl_pkg::*;
#(
    parameter int N_OPS = N_OPS_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             gt,
    output logic [IDX_W-1:0] sel,
    output logic             clr_best,
    output logic             ld_best,
    output logic [IDX_W-1:0] best_idx,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] cnt;
    logic             cnt_tc;

    max_search_ctrl_step_counter #(
        .N_OPS (N_OPS),
        .IDX_W (IDX_W)
    ) u_step_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (state == INIT),
        .en    (state == SCAN),
        .count (cnt),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Strict gt means a later equal operand never displaces the earlier index.
    always_ff @(posedge clk) begin
        if (rst || state == INIT) begin
            best_idx <= '0;
        end else if (state == SCAN && gt) begin
            best_idx <= cnt;
        end
    end

    always_comb begin
        state_next = state;
        sel        = '0;
        clr_best   = 1'b0;
        ld_best    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = INIT;
            end
            INIT: begin
                clr_best   = 1'b1;
                busy       = 1'b1;
                state_next = SCAN;
            end
            SCAN: begin
                busy    = 1'b1;
                sel     = cnt;
                ld_best = gt;
                if (cnt_tc) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_next = INIT;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_max_search_ctrl.sv
// Scoreboard bench for max_search_ctrl with a behavioural model of the best-register datapath.
module tb_max_search_ctrl;

    localparam int EV_CLR  = 0;
    localparam int EV_LD   = 1;
    localparam int EV_DONE = 2;

    typedef struct {
        int kind;
        int val;
        int lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       gt;
    logic [1:0] sel;
    logic       clr_best;
    logic       ld_best;
    logic [1:0] best_idx;
    logic       busy;
    logic       done;

    logic [4:0] ops [4];
    logic [4:0] bestReg = 5'd0;
    int         cycle = 0;
    int         startCycle = 0;
    int         checkCount = 0;
    int         failCount = 0;
    logic       prevDone = 1'b0;
    exp_t       expQ [$];

    max_search_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .gt       (gt),
        .sel      (sel),
        .clr_best (clr_best),
        .ld_best  (ld_best),
        .best_idx (best_idx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    assign gt = (ops[sel] > bestReg);

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (clr_best === 1'b1) bestReg <= 5'd0;
        else if (ld_best === 1'b1) bestReg <= ops[sel];
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic pushExp(input int kind, input int val, input int lat);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.lat  = lat;
        expQ.push_back(e);
    endtask

    task automatic handleEvent(input int kind, input int val, input int lat);
        exp_t e;
        if (expQ.size() == 0) begin
            checkCount++;
            failCount++;
            $display("[TB] FAIL unexpected_event: got kind %0d val %0d, expected none", kind, val);
        end else begin
            e = expQ.pop_front();
            checkOutput("event_kind", kind, e.kind);
            if (kind == e.kind) begin
                checkOutput("event_value", val, e.val);
                if (kind == EV_DONE) checkOutput("done_latency", lat, e.lat);
            end
        end
    endtask

    // Monitor: turns DUT strobes into events and checks them against the expected queue.
    always @(negedge clk) begin
        if (busy === 1'b1) checkOutput("clr_ld_exclusive", int'(clr_best & ld_best), 0);
        if (clr_best === 1'b1) handleEvent(EV_CLR, 0, 0);
        if (ld_best === 1'b1) handleEvent(EV_LD, int'(sel), 0);
        if (done === 1'b1 && !prevDone) handleEvent(EV_DONE, int'(best_idx), cycle - startCycle);
        prevDone = (done === 1'b1);
    end

    task automatic applyStimulus(input logic [4:0] o0, input logic [4:0] o1,
                                 input logic [4:0] o2, input logic [4:0] o3);
        @(negedge clk);
        ops[0] = o0;
        ops[1] = o1;
        ops[2] = o2;
        ops[3] = o3;
        start = 1'b1;
        startCycle = cycle + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input string name);
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) break;
            @(negedge clk);
        end
        checkOutput(name, int'(done === 1'b1), 1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_sel"}, int'(sel), 0);
        checkOutput({tag, "_clr_best"}, int'(clr_best), 0);
        checkOutput({tag, "_ld_best"}, int'(ld_best), 0);
        checkOutput({tag, "_best_idx"}, int'(best_idx), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        ops[0] = 5'd0;
        ops[1] = 5'd0;
        ops[2] = 5'd0;
        ops[3] = 5'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkAllZero("reset");

        $display("[TB] test 1: ops {3,2,1,5}");
        pushExp(EV_CLR, 0, 0);
        pushExp(EV_LD, 0, 0);
        pushExp(EV_LD, 3, 0);
        pushExp(EV_DONE, 3, 5);
        applyStimulus(5'd3, 5'd2, 5'd1, 5'd5);
        checkOutput("t1_busy_in_init", int'(busy), 1);
        waitDone("t1_done");

        $display("[TB] test 2: ops {4,4,4,4}");
        pushExp(EV_CLR, 0, 0);
        pushExp(EV_LD, 0, 0);
        pushExp(EV_DONE, 0, 5);
        applyStimulus(5'd4, 5'd4, 5'd4, 5'd4);
        waitDone("t2_done");

        $display("[TB] test 3: ops {0,0,0,0}");
        pushExp(EV_CLR, 0, 0);
        pushExp(EV_DONE, 0, 5);
        applyStimulus(5'd0, 5'd0, 5'd0, 5'd0);
        waitDone("t3_done");

        $display("[TB] test 4: ops {1,9,2,9}, start re-pulsed during scan");
        pushExp(EV_CLR, 0, 0);
        pushExp(EV_LD, 0, 0);
        pushExp(EV_LD, 1, 0);
        pushExp(EV_DONE, 1, 5);
        applyStimulus(5'd1, 5'd9, 5'd2, 5'd9);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone("t4_done");
        repeat (4) @(negedge clk);
        checkOutput("t4_done_held", int'(done), 1);
        checkOutput("t4_no_rerun_busy", int'(busy), 0);
        checkOutput("t4_best_idx_held", int'(best_idx), 1);

        $display("[TB] test 5: reset during scan at sel=2");
        pushExp(EV_CLR, 0, 0);
        pushExp(EV_LD, 0, 0);
        applyStimulus(5'd3, 5'd2, 5'd1, 5'd5);
        repeat (3) @(negedge clk);
        checkOutput("t5_sel_before_rst", int'(sel), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkAllZero("t5_after_rst");
        pushExp(EV_CLR, 0, 0);
        pushExp(EV_LD, 0, 0);
        pushExp(EV_LD, 3, 0);
        pushExp(EV_DONE, 3, 5);
        applyStimulus(5'd3, 5'd2, 5'd1, 5'd5);
        waitDone("t5_rerun_done");

        $display("[TB] test 6: restart from DONE with ops {7,1,1,1}");
        checkOutput("t6_best_idx_before", int'(best_idx), 3);
        pushExp(EV_CLR, 0, 0);
        pushExp(EV_LD, 0, 0);
        pushExp(EV_DONE, 0, 5);
        applyStimulus(5'd7, 5'd1, 5'd1, 5'd1);
        checkOutput("t6_done_dropped", int'(done), 0);
        waitDone("t6_done");

        repeat (3) @(negedge clk);
        checkOutput("queue_drained", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
